alu_multicycle: RTL and testbench

//  Parametrised execute-stage ALU, next generation of the single-cycle ALU. Keeps its 6-bit opcode map.

---
 rtl/alu_multicycle.sv | 180 ++++++++++++++++++
 tb/tb_alu_multicycle.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with iterative mul/div,
// valid/ready handshakes, status flags and flush.
module alu_multicycle #(
   parameter  int WIDTH   = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5:0]         operation,
   input  logic [WIDTH-1:0]   op1,
   input  logic [WIDTH-1:0]   op2,
   input  logic [SHAMT_W-1:0] shift_amt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic [WIDTH-1:0]   remainder,
   output logic               zero,
   output logic               neg,
   output logic               div_zero,
   output logic               illegal
);
   localparam int         CNT_W  = SHAMT_W + 1;
   localparam logic [5:0] OP_MUL = 6'd2;
   localparam logic [5:0] OP_DIV = 6'd3;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             is_div;
   logic             neg_q;
   logic             neg_r;
   logic             accept;
   logic             op_zero;
   logic             op_ill;
   logic             op_iter;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] mul_p;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_tr;
   logic [WIDTH-1:0] div_p;
   logic [WIDTH-1:0] div_a;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   assign out_valid = (state == DONE);
   assign zero      = (result == '0);
   assign neg       = result[WIDTH-1];

   // Handshake and opcode classification
   always_comb begin
      in_ready = (state == IDLE) || (state == DONE && out_ready);
      accept   = in_valid && in_ready && !flush;
      op_zero  = (op2 == '0);
      op_ill   = (operation > 6'd13);
      op_iter  = (operation == OP_MUL) ||
                 (operation == OP_DIV && !op_zero);
   end

   // Single-cycle results; div here only covers divide-by-zero
   always_comb begin
      alu_res = '0;
      unique case (operation)
         6'd0:    alu_res = op1 + op2;
         6'd1:    alu_res = op1 - op2;
         6'd3:    alu_res = '1;
         6'd4:    alu_res = op2 << shift_amt;
         6'd5:    alu_res = op2 >> shift_amt;
         6'd6:    alu_res = {{(WIDTH-1){1'b0}},
                             $signed(op1) < $signed(op2)};
         6'd7:    alu_res = op1 & op2;
         6'd8:    alu_res = op1 | op2;
         6'd9:    alu_res = op1 ^ op2;
         6'd10:   alu_res = ~(op1 | op2);
         6'd11:   alu_res = $signed(op2) >>> shift_amt;
         6'd12:   alu_res = op2 << (WIDTH / 2);
         6'd13:   alu_res = op2 << op1[SHAMT_W-1:0];
         default: alu_res = '0;
      endcase
   end

   // One shift-add or restoring-divide step on magnitudes
   always_comb begin
      mul_p  = b_q[0] ? p_q + a_q : p_q;
      div_sh = {p_q, a_q[WIDTH-1]};
      div_tr = div_sh - {1'b0, b_q};
      div_p  = div_tr[WIDTH] ? div_sh[WIDTH-1:0] : div_tr[WIDTH-1:0];
      div_a  = {a_q[WIDTH-2:0], ~div_tr[WIDTH]};
   end

   // Next-state logic; flush always returns to IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (accept)
               state_nx = op_iter ? BUSY : DONE;
            else if (state == DONE && out_ready)
               state_nx = IDLE;
         end
         BUSY: begin
            if (cnt == CNT_W'(1))
               state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush)
         state_nx = IDLE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Operand capture, iteration and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         result    <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         illegal   <= 1'b0;
         cnt       <= '0;
         p_q       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         is_div    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
      end else if (accept) begin
         div_zero <= (operation == OP_DIV) && op_zero;
         illegal  <= op_ill;
         cnt      <= CNT_W'(WIDTH);
         is_div   <= (operation == OP_DIV);
         neg_q    <= op1[WIDTH-1] ^ op2[WIDTH-1];
         neg_r    <= op1[WIDTH-1];
         p_q      <= '0;
         a_q      <= mag(op1);
         b_q      <= mag(op2);
         if (!op_iter) begin
            result    <= alu_res;
            remainder <= (operation == OP_DIV) ? op1 : '0;
         end
      end else if (state == BUSY) begin
         cnt <= cnt - 1'b1;
         if (is_div) begin
            p_q <= div_p;
            a_q <= div_a;
         end else begin
            p_q <= mul_p;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
         end
         if (cnt == CNT_W'(1)) begin
            if (is_div) begin
               result    <= neg_q ? -div_a : div_a;
               remainder <= neg_r ? -div_p : div_p;
            end else begin
               result    <= neg_q ? -mul_p : mul_p;
               remainder <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised self-checking bench for alu_multicycle
// against a plain-arithmetic reference model.
module tb_alu_multicycle;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [5:0]    operation = '0;
   logic [W-1:0]  op1 = '0;
   logic [W-1:0]  op2 = '0;
   logic [4:0]    shift_amt = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic [W-1:0]  remainder;
   logic          zero;
   logic          neg;
   logic          div_zero;
   logic          illegal;

   int total = 0;
   int bad = 0;

   alu_multicycle #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .operation(operation), .op1(op1), .op2(op2),
      .shift_amt(shift_amt), .out_valid(out_valid),
      .out_ready(out_ready), .result(result),
      .remainder(remainder), .zero(zero), .neg(neg),
      .div_zero(div_zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Reference: signed 64-bit arithmetic, truncated to W bits
   function automatic void model(
      input  logic [5:0]   op,
      input  logic [W-1:0] a,
      input  logic [W-1:0] b,
      input  logic [4:0]   sh,
      output logic [W-1:0] r,
      output logic [W-1:0] rm,
      output logic         dz,
      output logic         il
   );
      longint sa, sb, t, m;
      logic signed [W-1:0] s2;
      logic [4:0] va;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s2 = b;
      va = a[4:0];
      r = '0; rm = '0; dz = 1'b0; il = 1'b0;
      case (op)
         6'd0:  r = a + b;
         6'd1:  r = a - b;
         6'd2:  begin t = sa * sb; r = t[W-1:0]; end
         6'd3:  begin
            if (b == 0) begin
               r = '1; rm = a; dz = 1'b1;
            end else begin
               t = sa / sb; m = sa % sb;
               r = t[W-1:0]; rm = m[W-1:0];
            end
         end
         6'd4:  r = b << sh;
         6'd5:  r = b >> sh;
         6'd6:  r = (sa < sb) ? 1 : 0;
         6'd7:  r = a & b;
         6'd8:  r = a | b;
         6'd9:  r = a ^ b;
         6'd10: r = ~(a | b);
         6'd11: r = s2 >>> sh;
         6'd12: r = b << (W / 2);
         6'd13: r = b << va;
         default: il = 1'b1;
      endcase
   endfunction

   function automatic int exp_lat(input logic [5:0] op, input logic [W-1:0] b);
      if (op == 6'd2 || (op == 6'd3 && b != 0))
         return W + 1;
      return 1;
   endfunction

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return 32'h8000_0000;
         2: return '1;
         3: return W'($urandom_range(0, 20)) - 32'd10;
         default: return W'($urandom);
      endcase
   endfunction

   // Drive one op, wait for accept then result; lat=-1 on timeout
   task automatic run_op(
      input  logic [5:0]   op,
      input  logic [W-1:0] a,
      input  logic [W-1:0] b,
      input  logic [4:0]   sh,
      output int           lat,
      output int           busy_rdy
   );
      operation = op; op1 = a; op2 = b; shift_amt = sh;
      in_valid = 1'b1; out_ready = 1'b1;
      lat = -1; busy_rdy = 0;
      for (int i = 0; i < 200 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 1; i < 200; i++) begin
         if (out_valid) begin
            lat = i;
            break;
         end
         if (in_ready) busy_rdy++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
      end
      total++;
      if (zero !== 1'b1) begin
         bad++; $display("FAIL reset_zero got=%b want=1", zero);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
      end
      total++;
      if ({result, remainder, neg, div_zero, illegal} !== '0) begin
         bad++;
         $display("FAIL reset_data got r=%h rm=%h n=%b dz=%b il=%b want all 0",
                  result, remainder, neg, div_zero, illegal);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      operation = 6'd0; op1 = 32'd5; op2 = 32'd7;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || result !== 32'd12) begin
         bad++; $display("FAIL b2b_add got v=%b r=%h want v=1 r=0000000c",
                         out_valid, result);
      end
      operation = 6'd1; op1 = 32'd3; op2 = 32'd5;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL b2b_ready got=%b want=1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE || neg !== 1'b1) begin
         bad++; $display("FAIL b2b_sub got v=%b r=%h n=%b want v=1 r=fffffffe n=1",
                         out_valid, result, neg);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      int lat, br;
      logic [W-1:0] er, erm;
      logic edz, eil;
      run_op(6'd2, -32'sd6, 32'd7, 5'd0, lat, br);
      total++;
      if (lat !== W + 1 || result !== 32'hFFFF_FFD6) begin
         bad++; $display("FAIL mul_basic got lat=%0d r=%h want lat=%0d r=ffffffd6",
                         lat, result, W + 1);
      end
      total++;
      if (br !== 0) begin
         bad++; $display("FAIL mul_busy_ready got=%0d ready cycles want=0", br);
      end
      for (int k = 0; k < 12; k++) begin
         logic [W-1:0] a, b;
         a = rnd_val(); b = rnd_val();
         model(6'd2, a, b, 5'd0, er, erm, edz, eil);
         run_op(6'd2, a, b, 5'd0, lat, br);
         total++;
         if (lat !== W + 1 || result !== er || remainder !== erm) begin
            bad++;
            $display("FAIL mul_rand a=%h b=%h got lat=%0d r=%h rm=%h want lat=%0d r=%h rm=%h",
                     a, b, lat, result, remainder, W + 1, er, erm);
         end
      end
   endtask

   task automatic test_div();
      int lat, br;
      logic [W-1:0] er, erm;
      logic edz, eil;
      run_op(6'd3, -32'sd7, 32'd2, 5'd0, lat, br);
      total++;
      if (result !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF ||
          div_zero !== 1'b0 || lat !== W + 1) begin
         bad++; $display("FAIL div_neg got r=%h rm=%h dz=%b lat=%0d want r=fffffffd rm=ffffffff dz=0",
                         result, remainder, div_zero, lat);
      end
      run_op(6'd3, 32'd9, 32'd0, 5'd0, lat, br);
      total++;
      if (lat !== 1 || result !== 32'hFFFF_FFFF || remainder !== 32'd9 ||
          div_zero !== 1'b1) begin
         bad++; $display("FAIL div_zero got lat=%0d r=%h rm=%h dz=%b want lat=1 r=ffffffff rm=9 dz=1",
                         lat, result, remainder, div_zero);
      end
      run_op(6'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, lat, br);
      total++;
      if (result !== 32'h8000_0000 || remainder !== 32'd0 || div_zero !== 1'b0) begin
         bad++; $display("FAIL div_min got r=%h rm=%h dz=%b want r=80000000 rm=0 dz=0",
                         result, remainder, div_zero);
      end
      for (int k = 0; k < 14; k++) begin
         logic [W-1:0] a, b;
         a = rnd_val(); b = rnd_val();
         model(6'd3, a, b, 5'd0, er, erm, edz, eil);
         run_op(6'd3, a, b, 5'd0, lat, br);
         total++;
         if (lat !== exp_lat(6'd3, b) || result !== er ||
             remainder !== erm || div_zero !== edz) begin
            bad++;
            $display("FAIL div_rand a=%h b=%h got lat=%0d r=%h rm=%h dz=%b want lat=%0d r=%h rm=%h dz=%b",
                     a, b, lat, result, remainder, div_zero,
                     exp_lat(6'd3, b), er, erm, edz);
         end
      end
   endtask

   task automatic test_single();
      int lat, br;
      logic [W-1:0] er, erm;
      logic edz, eil;
      run_op(6'd11, 32'd0, 32'h8000_0000, 5'd4, lat, br);
      total++;
      if (result !== 32'hF800_0000 || lat !== 1) begin
         bad++; $display("FAIL sra got r=%h lat=%0d want r=f8000000 lat=1", result, lat);
      end
      run_op(6'd12, 32'd0, 32'h0000_1234, 5'd0, lat, br);
      total++;
      if (result !== 32'h1234_0000) begin
         bad++; $display("FAIL lui got r=%h want r=12340000", result);
      end
      run_op(6'd20, 32'd55, 32'd66, 5'd3, lat, br);
      total++;
      if (illegal !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || lat !== 1) begin
         bad++; $display("FAIL illegal got il=%b r=%h z=%b lat=%0d want il=1 r=0 z=1 lat=1",
                         illegal, result, zero, lat);
      end
      for (int k = 0; k < 60; k++) begin
         logic [W-1:0] a, b;
         logic [5:0] op;
         logic [4:0] sh;
         a = rnd_val(); b = rnd_val(); sh = 5'($urandom);
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(14, 63))
                                          : 6'($urandom_range(0, 13));
         model(op, a, b, sh, er, erm, edz, eil);
         run_op(op, a, b, sh, lat, br);
         total++;
         if (lat !== exp_lat(op, b) || result !== er || remainder !== erm ||
             div_zero !== edz || illegal !== eil || zero !== (er == 0) ||
             neg !== er[W-1]) begin
            bad++;
            $display("FAIL op_rand op=%0d a=%h b=%h sh=%0d got lat=%0d r=%h rm=%h dz=%b il=%b z=%b n=%b want lat=%0d r=%h rm=%h dz=%b il=%b",
                     op, a, b, sh, lat, result, remainder, div_zero, illegal,
                     zero, neg, exp_lat(op, b), er, erm, edz, eil);
         end
      end
   endtask

   task automatic test_hold();
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      operation = 6'd6; op1 = 32'hFFFF_FFFF; op2 = 32'd1;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      operation = 6'd0; op1 = 32'd1; op2 = 32'd1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (out_valid !== 1'b1 || result !== 32'd1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL hold cyc=%0d got v=%b r=%h rdy=%b want v=1 r=1 rdy=0",
                            i, out_valid, result, in_ready);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || result !== 32'd2) begin
         bad++; $display("FAIL hold_release got v=%b r=%h want v=1 r=2",
                         out_valid, result);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_flush_reset();
      int lat, br;
      operation = 6'd3; op1 = 32'd100; op2 = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      flush = 1'b1;
      operation = 6'd0; op1 = 32'd40; op2 = 32'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd2) begin
         bad++; $display("FAIL flush got v=%b rdy=%b r=%h want v=0 rdy=1 r=2",
                         out_valid, in_ready, result);
      end
      repeat (W + 4) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || result !== 32'd2) begin
         bad++; $display("FAIL flush_abandon got v=%b r=%h want v=0 r=2",
                         out_valid, result);
      end
      operation = 6'd2; op1 = 32'd3; op2 = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 ||
          in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_mid got v=%b r=%h z=%b rdy=%b want v=0 r=0 z=1 rdy=1",
                         out_valid, result, zero, in_ready);
      end
      reset_n = 1'b1;
      repeat (W + 4) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_abandon got v=%b want v=0", out_valid);
      end
      run_op(6'd0, 32'd123, 32'd877, 5'd0, lat, br);
      total++;
      if (lat !== 1 || result !== 32'd1000) begin
         bad++; $display("FAIL after_reset_add got lat=%0d r=%h want lat=1 r=000003e8",
                         lat, result);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_mul();
      test_div();
      test_single();
      test_hold();
      test_flush_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
